// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte producers, the round-robin arbiter and the shared UART transmitter.
// The arbiter takes the master modport; the producer/transmitter side takes the slave modport.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  logic [NUM_REQ-1:0]           reqValid;
  logic [NUM_REQ*DATA_BITS-1:0] reqData;
  logic [NUM_REQ-1:0]           reqAck;
  logic                         txStart;
  logic [DATA_BITS-1:0]         txData;
  logic                         txBusy;
  logic                         txDone;

  modport master (
    input  reqValid, reqData, txBusy, txDone,
    output reqAck, txStart, txData
  );

  modport slave (
    output reqValid, reqData, txBusy, txDone,
    input  reqAck, txStart, txData
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_ARB_TIMEOUT_EN to enable the frame watchdog (err pulse after TIMEOUT_CYCLES stuck cycles).
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        i_en,
  uart_tx_arbiter_if.master                           io_arb,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] o_grantId,
  output logic                                        o_arbBusy,
  output logic                                        o_err
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                r_state;
  logic [GW-1:0]         r_lastGrant;
  logic [GW-1:0]         r_grantId;
  logic [NUM_REQ-1:0]    r_reqAck;
  logic                  r_txStart;
  logic [DATA_BITS-1:0]  r_txData;
  logic                  w_found;
  logic [GW-1:0]         w_idx;
  logic [GW-1:0]         w_winner;
  logic [DATA_BITS-1:0]  w_winData;
  logic                  w_timeout;

  // Scan starts just after the last winner, so the previous owner is considered last.
  always_comb begin
    w_found   = 1'b0;
    w_idx     = '0;
    w_winner  = '0;
    w_winData = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = GW'((int'(r_lastGrant) + k) % NUM_REQ);
      if (!w_found && io_arb.reqValid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == GW'(i)) begin
        w_winData = io_arb.reqData[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == WAIT_BUSY || r_state == WAIT_DONE) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign o_err     = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lastGrant <= GW'(NUM_REQ - 1);
      r_grantId   <= '0;
      r_reqAck    <= '0;
      r_txStart   <= 1'b0;
      r_txData    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (i_en && w_found) begin
            r_txData    <= w_winData;
            r_grantId   <= w_winner;
            r_lastGrant <= w_winner;
            r_reqAck    <= NUM_REQ'(1) << w_winner;
            r_txStart   <= 1'b1;
            r_state     <= START;
          end
        end
        START: begin
          r_reqAck  <= '0;
          r_txStart <= 1'b0;
          r_state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (w_timeout) begin
            r_state <= IDLE;
`ifdef UART_ARB_TIMEOUT_EN
            r_err   <= 1'b1;
`endif
          end else if (io_arb.txBusy) begin
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // A normal completion on the watchdog's last cycle is not an error.
          if (io_arb.txDone || !io_arb.txBusy) begin
            r_state <= IDLE;
          end else if (w_timeout) begin
            r_state <= IDLE;
`ifdef UART_ARB_TIMEOUT_EN
            r_err   <= 1'b1;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_arb.reqAck  = r_reqAck;
  assign io_arb.txStart = r_txStart;
  assign io_arb.txData  = r_txData;
  assign o_grantId      = r_grantId;
  assign o_arbBusy      = (r_state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a queue-level round-robin model predicts the grant order,
// a monitor checks every txStart against it. Define UART_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ        = 4;
  localparam int DATA_BITS      = 8;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int GW             = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic [GW-1:0] grantId;
  logic          arbBusy;
  logic          err;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS)) arbIf ();

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_en(en), .io_arb(arbIf),
    .o_grantId(grantId), .o_arbBusy(arbBusy), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
  } expT;

  expT        expQ[$];
  expT        monE;
  logic [7:0] prodQ [NUM_REQ][$];
  logic [7:0] stageQ[NUM_REQ][$];
  int         modelLast     = NUM_REQ - 1;
  int         checks        = 0;
  int         errors        = 0;
  int         cyc           = 0;
  int         startCyc      = 0;
  int         framesStarted = 0;
  int         framesDone    = 0;
  int         errPulses     = 0;
  int         remain        = 0;
  int         frameLenForce = 0;
  bit         mute          = 1'b0;
  bit         enJitter      = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout expected=event", name);
  endtask

  always @(posedge clk) cyc++;

  // Producers: present the head of each queue, pop it once acked.
  always @(negedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst_n && arbIf.reqAck[i] && prodQ[i].size() > 0) void'(prodQ[i].pop_front());
      arbIf.reqValid[i] = (prodQ[i].size() != 0);
      arbIf.reqData[i*DATA_BITS +: DATA_BITS] = (prodQ[i].size() != 0) ? prodQ[i][0] : 8'h00;
    end
  end

  // Transmitter model: busy for a few cycles after start, then a one-cycle done.
  always @(negedge clk) begin
    if (!rst_n) begin
      arbIf.txBusy = 1'b0;
      arbIf.txDone = 1'b0;
      remain       = 0;
    end else begin
      arbIf.txDone = 1'b0;
      if (arbIf.txStart && !mute) begin
        arbIf.txBusy = 1'b1;
        remain = (frameLenForce > 0) ? frameLenForce : int'($urandom_range(2, 5));
      end else if (arbIf.txBusy) begin
        remain--;
        if (remain == 0) begin
          arbIf.txBusy = 1'b0;
          arbIf.txDone = 1'b1;
          framesDone++;
        end
      end
    end
  end

  // Monitor: every frame start is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (arbIf.txStart) begin
        checkOutput("startAfterDone", framesDone, framesStarted);
        framesStarted++;
        startCyc = cyc;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedStart actual=txData %0h expected=no start", arbIf.txData);
        end else begin
          monE = expQ.pop_front();
          checkOutput("txData", arbIf.txData, monE.data);
          checkOutput("grantId", grantId, monE.id);
          checkOutput("reqAck", arbIf.reqAck, 32'(1) << monE.id);
        end
      end else if (arbIf.reqAck != '0) begin
        checks++;
        errors++;
        $display("[TB] FAIL ackWithoutStart actual=%0h expected=0", arbIf.reqAck);
      end
      if (err) begin
        errPulses++;
`ifdef UART_ARB_TIMEOUT_EN
        checkOutput("errLatency", cyc - startCyc, 17);
        checkOutput("arbBusyAtErr", arbBusy, 0);
        framesDone++;
`endif
      end
    end
  end

  task automatic addByte(input int id, input logic [7:0] b);
    stageQ[id].push_back(b);
  endtask

  // Round-robin over the staged queues yields the full expected grant order.
  task automatic applyStimulus();
    logic [7:0] tmp[NUM_REQ][$];
    int         left = 0;
    bit         found;
    int         idx;
    expT        e;
    for (int i = 0; i < NUM_REQ; i++) begin
      tmp[i] = stageQ[i];
      left  += tmp[i].size();
    end
    while (left > 0) begin
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (modelLast + k) % NUM_REQ;
        if (!found && tmp[idx].size() > 0) begin
          found     = 1'b1;
          e.id      = idx;
          e.data    = tmp[idx].pop_front();
          expQ.push_back(e);
          modelLast = idx;
          left--;
        end
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      foreach (stageQ[i][j]) prodQ[i].push_back(stageQ[i][j]);
      stageQ[i].delete();
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    int pend;
    do begin
      @(negedge clk);
      if (enJitter) en = ($urandom_range(0, 3) != 0);
      pend = 0;
      for (int i = 0; i < NUM_REQ; i++) pend += prodQ[i].size();
      n++;
    end while ((expQ.size() != 0 || arbBusy || pend != 0) && n < 2000);
    if (n >= 2000) begin
      failNow(name);
      expQ.delete();
      for (int i = 0; i < NUM_REQ; i++) prodQ[i].delete();
    end
    en = 1'b1;
    @(negedge clk);
    checkOutput(name, arbBusy, 0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    expQ.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      prodQ[i].delete();
      stageQ[i].delete();
    end
    modelLast     = NUM_REQ - 1;
    framesStarted = 0;
    framesDone    = 0;
    rst_n         = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    int quiet;
    int n;

    doReset();
    checkOutput("rstReqAck", arbIf.reqAck, 0);
    checkOutput("rstTxStart", arbIf.txStart, 0);
    checkOutput("rstTxData", arbIf.txData, 0);
    checkOutput("rstGrantId", grantId, 0);
    checkOutput("rstArbBusy", arbBusy, 0);
    checkOutput("rstErr", err, 0);

    en = 1'b1;
    addByte(0, 8'h55);
    applyStimulus();
    drain("singleFrame");

    doReset();
    en = 1'b1;
    addByte(0, 8'h11); addByte(0, 8'h11);
    addByte(1, 8'h22); addByte(2, 8'h33); addByte(3, 8'h44);
    applyStimulus();
    drain("allFour");

    addByte(1, 8'hB1);
    applyStimulus();
    drain("setLast1");
    addByte(0, 8'hC0); addByte(3, 8'hC3);
    applyStimulus();
    drain("wrapOrder");

    en = 1'b0;
    addByte(1, 8'hA1);
    applyStimulus();
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (arbIf.txStart || arbIf.reqAck != '0) quiet++;
    end
    checkOutput("enLowNoGrant", quiet, 0);
    en = 1'b1;
    @(negedge clk);
    checkOutput("enRiseAck", arbIf.reqAck, 4'b0010);
    drain("enRise");

    frameLenForce = 10;
    addByte(0, 8'h5A);
    applyStimulus();
    n = 0;
    while (!arbIf.txBusy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) failNow("waitBusy");
    @(negedge clk);
    en = 1'b0;
    addByte(2, 8'h96);
    applyStimulus();
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (!arbBusy || arbIf.txStart) quiet++;
    end
    checkOutput("enLowHold", quiet, 0);
    en = 1'b1;
    frameLenForce = 0;
    drain("afterDone");

    enJitter = 1'b1;
    repeat (8) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt = $urandom_range(0, 3);
        for (int j = 0; j < cnt; j++) addByte(i, 8'($urandom));
      end
      applyStimulus();
      drain("randomBatch");
    end
    enJitter = 1'b0;
    en = 1'b1;

    mute = 1'b1;
    addByte(2, 8'h3C);
    applyStimulus();
    n = 0;
    while (!arbIf.txStart && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) failNow("waitStart");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstTxStart", arbIf.txStart, 0);
    checkOutput("midRstReqAck", arbIf.reqAck, 0);
    checkOutput("midRstTxData", arbIf.txData, 0);
    checkOutput("midRstGrantId", grantId, 0);
    checkOutput("midRstArbBusy", arbBusy, 0);
    checkOutput("midRstErr", err, 0);
    doReset();
    mute = 1'b0;
    en = 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    mute = 1'b1;
    addByte(1, 8'h77);
    applyStimulus();
    n = 0;
    while (!err && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) failNow("waitErr");
    @(negedge clk);
    mute = 1'b0;
    drain("afterTimeout");
    checkOutput("errPulseCount", errPulses, 1);
`else
    checkOutput("errStaysLow", errPulses, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
